// File: rtl/palette_loader.sv
// palette_loader: captures a 16-byte palette from the ioctl download stream.
// A palette that arrived complete is held as pending and made active on the
// next rising edge of vblank, so the core never sees a partial palette.
module palette_loader #(
    parameter logic [7:0]   PAL_INDEX   = 8'd3,
    parameter logic [127:0] DEFAULT_PAL = 128'h00000032cd320000ff00ffff00000000
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         ioctl_download,
    input  logic [7:0]   ioctl_index,
    input  logic         ioctl_wr,
    input  logic [15:0]  ioctl_addr,
    input  logic [7:0]   ioctl_data,
    input  logic         vblank,
    output logic [127:0] palette,
    output logic         pal_busy,
    output logic         pal_pending,
    output logic         pal_error,
    output logic         pal_loaded
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t         state;
    logic [127:0]   staging;
    logic [15:0]    mask;
    logic [15:0]    mask_nxt;
    logic           sel_q;
    logic           vblank_q;

    logic sel;
    logic sel_rise;
    logic sel_fall;
    logic vb_rise;
    logic accept;
    logic start;

    assign sel      = ioctl_download & (ioctl_index == PAL_INDEX);
    assign sel_rise = sel & ~sel_q;
    assign sel_fall = ~sel & sel_q;
    assign vb_rise  = vblank & ~vblank_q;
    assign accept   = sel & ioctl_wr & (ioctl_addr < 16'd16);
    // A new download begins from IDLE or replaces a pending palette.
    assign start    = sel_rise & (state != LOAD);

    // Next written-mask: cleared on a new download, then the accepted byte
    // (possibly in the same cycle) marks its slot.
    always_comb begin
        mask_nxt = start ? 16'h0000 : mask;
        if (accept)
            mask_nxt[ioctl_addr[3:0]] = 1'b1;
    end

    // Edge-detect history, staging bytes and written mask.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sel_q    <= 1'b0;
            vblank_q <= 1'b0;
            staging  <= DEFAULT_PAL;
            mask     <= 16'h0000;
        end else begin
            sel_q    <= sel;
            vblank_q <= vblank;
            mask     <= mask_nxt;
            for (int i = 0; i < 16; i++) begin
                if (accept && (ioctl_addr[3:0] == i[3:0]))
                    staging[127-8*i -: 8] <= ioctl_data;
            end
        end
    end

    // Load/commit FSM with registered status flags and active palette.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            palette     <= DEFAULT_PAL;
            pal_busy    <= 1'b0;
            pal_pending <= 1'b0;
            pal_error   <= 1'b0;
            pal_loaded  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_rise) begin
                        state       <= LOAD;
                        pal_busy    <= 1'b1;
                        pal_pending <= 1'b0;
                        pal_error   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (sel_fall) begin
                        pal_busy <= 1'b0;
                        if (mask == 16'hFFFF) begin
                            state       <= PENDING;
                            pal_pending <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            pal_error <= 1'b1;
                        end
                    end
                end
                PENDING: begin
                    // A fresh download wins over a coincident vblank edge.
                    if (sel_rise) begin
                        state       <= LOAD;
                        pal_busy    <= 1'b1;
                        pal_pending <= 1'b0;
                        pal_error   <= 1'b0;
                    end else if (vb_rise) begin
                        state       <= IDLE;
                        palette     <= staging;
                        pal_loaded  <= 1'b1;
                        pal_pending <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    pal_busy    <= 1'b0;
                    pal_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader: load, reject, overflow, foreign index,
// reset during PENDING and download restart coincident with vblank.
module tb_palette_loader;

    localparam logic [127:0] DEF = 128'h00000032cd320000ff00ffff00000000;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic         ioctl_download;
    logic [7:0]   ioctl_index;
    logic         ioctl_wr;
    logic [15:0]  ioctl_addr;
    logic [7:0]   ioctl_data;
    logic         vblank;
    logic [127:0] palette;
    logic         pal_busy;
    logic         pal_pending;
    logic         pal_error;
    logic         pal_loaded;

    int checks = 0;
    int errors = 0;

    palette_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .vblank         (vblank),
        .palette        (palette),
        .pal_busy       (pal_busy),
        .pal_pending    (pal_pending),
        .pal_error      (pal_error),
        .pal_loaded     (pal_loaded)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Flags packed as {busy, pending, error, loaded}.
    function automatic logic [127:0] flags();
        return {124'd0, pal_busy, pal_pending, pal_error, pal_loaded};
    endfunction

    // Palette holding base, base+1, ... with the first byte at the top.
    function automatic logic [127:0] seq_pal(input logic [7:0] base);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 16; i++)
            p[127-8*i -: 8] = base + i[7:0];
        return p;
    endfunction

    // Raise download, then n byte writes at addr 0..n-1; download stays high.
    task automatic download(input logic [7:0] idx, input int n, input logic [7:0] base);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        tick();
        for (int i = 0; i < n; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = i[15:0];
            ioctl_data = base + i[7:0];
            tick();
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic drop();
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic vb_pulse();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = 16'd0; ioctl_data = 8'd0; vblank = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_palette", palette, DEF);
        chk("reset_flags", flags(), 128'h0);

        // Idle for 1000 cycles with vblank toggling.
        for (int c = 0; c < 1000; c++) begin
            vblank = (c % 20) >= 10;
            tick();
        end
        vblank = 1'b0; tick();
        chk("idle_palette", palette, DEF);
        chk("idle_flags", flags(), 128'h0);

        // Full 16-byte load, commit on vblank 100 cycles later.
        download(8'd3, 16, 8'h00);
        chk("load_busy", flags(), 128'b1000);
        drop();
        chk("load_pending", flags(), 128'b0100);
        for (int c = 0; c < 99; c++) tick();
        chk("gap_pending", flags(), 128'b0100);
        chk("gap_palette", palette, DEF);
        vblank = 1'b1;
        #1;
        chk("pre_edge_palette", palette, DEF);
        tick();
        chk("commit_palette", palette, 128'h000102030405060708090a0b0c0d0e0f);
        chk("commit_flags", flags(), 128'b0001);
        vblank = 1'b0; tick();

        // Short download is rejected and nothing changes on vblank.
        download(8'd3, 12, 8'hA0);
        drop();
        chk("short_flags", flags(), 128'b0011);
        vb_pulse();
        chk("short_palette", palette, seq_pal(8'h00));
        chk("short_flags_vb", flags(), 128'b0011);

        // 20-byte download: bytes 16..19 ignored, error clears on new load.
        download(8'd3, 20, 8'h10);
        chk("long_busy", flags(), 128'b1001);
        drop();
        chk("long_pending", flags(), 128'b0101);
        vb_pulse();
        chk("long_palette", palette, seq_pal(8'h10));
        chk("long_flags", flags(), 128'b0001);

        // Foreign index is ignored entirely.
        download(8'd1, 16, 8'hEE);
        chk("idx1_flags_mid", flags(), 128'b0001);
        drop();
        vb_pulse();
        chk("idx1_palette", palette, seq_pal(8'h10));
        chk("idx1_flags", flags(), 128'b0001);

        // Reset while PENDING discards the staged palette.
        download(8'd3, 16, 8'h30);
        drop();
        chk("rst_pend_pre", flags(), 128'b0101);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_pend_palette", palette, DEF);
        chk("rst_pend_flags", flags(), 128'h0);
        vb_pulse();
        chk("rst_pend_vb_palette", palette, DEF);
        chk("rst_pend_vb_flags", flags(), 128'h0);

        // New download starting with vb_rise while PENDING wins.
        download(8'd3, 16, 8'h40);
        drop();
        chk("restart_pending", flags(), 128'b0100);
        ioctl_download = 1'b1; ioctl_index = 8'd3; vblank = 1'b1;
        tick();
        chk("restart_busy", flags(), 128'b1000);
        chk("restart_palette", palette, DEF);
        for (int i = 0; i < 16; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = i[15:0]; ioctl_data = 8'h50 + i[7:0];
            tick();
        end
        ioctl_wr = 1'b0;
        drop();
        chk("restart_pending2", flags(), 128'b0100);
        vblank = 1'b0; tick();
        chk("restart_hold", palette, DEF);
        vblank = 1'b1; tick();
        chk("restart_palette2", palette, seq_pal(8'h50));
        chk("restart_flags2", flags(), 128'b0001);
        vblank = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
